// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, default widths
// and the fetch-group payload layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned FETCH_ADDR_W    = 10;
  localparam int unsigned FETCH_DATA_W    = 32;
  localparam int unsigned FETCH_ISSUE_W   = 2;
  localparam int unsigned FETCH_MAX_ISSUE = 4;

  // Fetch group as seen by decode in the default configuration; slot i sits at instr[i].
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]                     pc;
    logic [FETCH_ISSUE_W-1:0][FETCH_DATA_W-1:0]  instr;
    logic [FETCH_ISSUE_W-1:0]                    slot_v;
  } fetch_group_t;

endpackage

// File: rtl/fetch_rom_stage_rom.sv
// Multi-port synchronous-read instruction ROM (rom_mport): NPORTS independent
// addresses, one shared read enable, registered read data.
module rom_mport #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NPORTS     = 2,
  parameter string       INIT_FILE  = "program.mem"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NPORTS*ADDR_WIDTH-1:0] addr,
  output logic [NPORTS*DATA_WIDTH-1:0] data
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Each word holds its own address.
  initial begin
    for (int unsigned w = 0; w < DEPTH; w++) begin
      mem[w] = DATA_WIDTH'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        data[p*DATA_WIDTH +: DATA_WIDTH] <= mem[addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

endmodule

// File: rtl/fetch_rom_stage.sv
// Multi-issue fetch stage: owns the fetch PC, reads ISSUE_WIDTH consecutive words per
// group with valid/ready backpressure and branch redirects. Optional FETCH_BOUNDS_CHECK_EN.
module fetch_rom_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned ROM_DEPTH   = 2**ADDR_WIDTH,
  parameter string       INIT_FILE   = "program.mem"
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              redirect_i,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc_i,
  input  logic                              out_ready_i,
  output logic                              out_valid_o,
  output logic [ADDR_WIDTH-1:0]             out_pc_o,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_instr_o,
  output logic [ISSUE_WIDTH-1:0]            out_slot_v_o
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic                              fault_o
`endif
);

  localparam int unsigned INSTR_W = ISSUE_WIDTH * DATA_WIDTH;

  if (ISSUE_WIDTH < 1 || ISSUE_WIDTH > FETCH_MAX_ISSUE) begin : g_bad_issue_width
    $error("fetch_rom_stage: ISSUE_WIDTH out of range");
  end
  if (ROM_DEPTH < 1 || ROM_DEPTH > 2**ADDR_WIDTH) begin : g_bad_rom_depth
    $error("fetch_rom_stage: ROM_DEPTH out of range");
  end

  logic [ADDR_WIDTH-1:0]                  pc_q;
  logic [ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] slot_addr_c;
  logic [ISSUE_WIDTH-1:0]                 in_range_c;
  logic [INSTR_W-1:0]                     rom_data;
  logic                                   adv_c;
  logic                                   rd_en_c;

  assign adv_c   = !out_valid_o || out_ready_i;
  // A redirect squashes the read so the held instruction bits stay untouched.
  assign rd_en_c = adv_c && !redirect_i;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot_addr
    assign slot_addr_c[i] = pc_q + ADDR_WIDTH'(i);
  end

  rom_mport #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NPORTS     (ISSUE_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_en_c),
    .addr  (slot_addr_c),
    .data  (rom_data)
  );

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam int unsigned CMP_W = ADDR_WIDTH + 1;

  logic [ISSUE_WIDTH-1:0] oob_q;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_bounds
    assign in_range_c[i] = {1'b0, slot_addr_c[i]} < CMP_W'(ROM_DEPTH);
    assign out_instr_o[i*DATA_WIDTH +: DATA_WIDTH] =
      oob_q[i] ? DATA_WIDTH'(NOP_INSTR) : rom_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Out-of-range flags travel with the group they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_q   <= '0;
      fault_o <= 1'b0;
    end else if (redirect_i) begin
      fault_o <= 1'b0;
    end else if (adv_c) begin
      oob_q   <= ~in_range_c;
      fault_o <= ~&in_range_c;
    end
  end
`else
  assign in_range_c  = '1;
  assign out_instr_o = rom_data;
`endif

  // PC and group-valid bookkeeping; a faulting slot 0 parks the PC until a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= ADDR_WIDTH'(RESET_PC);
      out_valid_o  <= 1'b0;
      out_pc_o     <= '0;
      out_slot_v_o <= '0;
    end else if (redirect_i) begin
      pc_q         <= redirect_pc_i;
      out_valid_o  <= 1'b0;
      out_slot_v_o <= '0;
    end else if (adv_c) begin
      pc_q         <= in_range_c[0] ? pc_q + ADDR_WIDTH'(ISSUE_WIDTH) : pc_q;
      out_valid_o  <= 1'b1;
      out_pc_o     <= pc_q;
      out_slot_v_o <= in_range_c;
    end
  end

endmodule

// File: tb/tb_fetch_rom_stage.sv
// Self-checking bench for fetch_rom_stage: a cycle model predicts each group, pushes it
// to a scoreboard queue and the scenario tasks pop and compare after every edge.
module tb_fetch_rom_stage;
  import fetch_pkg::*;

  localparam int unsigned AW = FETCH_ADDR_W;
  localparam int unsigned DW = FETCH_DATA_W;
  localparam int unsigned IW = FETCH_ISSUE_W;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam int unsigned DEPTH = 64;
`else
  localparam int unsigned DEPTH = 2**AW;
`endif

  typedef struct packed {
    logic         valid;
    fetch_group_t grp;
    logic         fault;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              redirect_i;
  logic [AW-1:0]     redirect_pc_i;
  logic              out_ready_i;
  logic              out_valid_o;
  logic [AW-1:0]     out_pc_o;
  logic [IW*DW-1:0]  out_instr_o;
  logic [IW-1:0]     out_slot_v_o;
  logic              fault;

  fetch_rom_stage #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .ISSUE_WIDTH (IW),
    .RESET_PC    (0),
    .ROM_DEPTH   (DEPTH),
    .INIT_FILE   ("")
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .out_ready_i   (out_ready_i),
    .out_valid_o   (out_valid_o),
    .out_pc_o      (out_pc_o),
    .out_instr_o   (out_instr_o),
    .out_slot_v_o  (out_slot_v_o)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .fault_o       (fault)
`endif
  );

`ifndef FETCH_BOUNDS_CHECK_EN
  assign fault = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            total;
  int            bad;
  exp_t          exp_q[$];
  logic [AW-1:0] m_pc;
  exp_t          m_out;

  // ROM image is word[i] = i.
  task automatic model_reset();
    m_pc  = '0;
    m_out = '0;
  endtask

  task automatic model_edge(input logic redir, input logic [AW-1:0] rpc, input logic rdy);
    logic [AW-1:0] a;
    if (redir) begin
      m_pc             = rpc;
      m_out.valid      = 1'b0;
      m_out.grp.slot_v = '0;
      m_out.fault      = 1'b0;
    end else if (!m_out.valid || rdy) begin
      m_out.valid  = 1'b1;
      m_out.grp.pc = m_pc;
      m_out.fault  = 1'b0;
      for (int i = 0; i < int'(IW); i++) begin
        a = m_pc + AW'(i);
        if (32'(a) < DEPTH) begin
          m_out.grp.slot_v[i] = 1'b1;
          m_out.grp.instr[i]  = DW'(a);
        end else begin
          m_out.grp.slot_v[i] = 1'b0;
          m_out.grp.instr[i]  = NOP_INSTR;
          m_out.fault         = 1'b1;
        end
      end
      if (m_out.grp.slot_v[0]) m_pc = m_pc + AW'(IW);
    end
  endtask

  function automatic exp_t sample();
    exp_t s;
    s.valid      = out_valid_o;
    s.grp.pc     = out_pc_o;
    s.grp.instr  = out_instr_o;
    s.grp.slot_v = out_slot_v_o;
    s.fault      = fault;
    return s;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("valid=%0b pc=%h instr=%h slot_v=%b fault=%0b",
                     e.valid, e.grp.pc, e.grp.instr, e.grp.slot_v, e.fault);
  endfunction

  task automatic drive(input logic redir, input logic [AW-1:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    out_ready_i   = rdy;
    model_edge(redir, rpc, rdy);
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t want;
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    out_ready_i = 1'b1;
    model_reset();
    #12;
    got = sample();
    want = m_out;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset: got %s want %s", fmt(got), fmt(want));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    exp_t got;
    exp_t want;
    for (int n = 0; n < 20; n++) begin
      drive(1'b0, '0, 1'b1);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stream[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall();
    exp_t got;
    exp_t want;
    logic rdy;
    do_reset();
    for (int n = 0; n < 7; n++) begin
      rdy = !(n >= 3 && n <= 5);
      drive(1'b0, '0, rdy);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stall[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_redirect();
    exp_t got;
    exp_t want;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drive(n == 5, AW'(10'h101), 1'b1);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL redirect[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_wrap();
    exp_t got;
    exp_t want;
    for (int n = 0; n < 4; n++) begin
      drive(n == 0, AW'(10'h3FF), 1'b1);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wrap[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

`ifdef FETCH_BOUNDS_CHECK_EN
  task automatic test_bounds();
    exp_t got;
    exp_t want;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) drive(1'b1, '0, 1'b1);
      else        drive(n == 0, AW'(DEPTH - 1), 1'b1);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL bounds[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    exp_t got;
    exp_t want;
    for (int n = 0; n < 6; n++) begin
      case (n)
        0:       drive(1'b1, AW'(10'h050), 1'b1);
        1:       drive(1'b1, AW'(10'h030), 1'b1);
        3:       drive(1'b1, AW'(10'h011), 1'b0);
        default: drive(1'b0, '0, 1'b1);
      endcase
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got;
    exp_t want;
    do_reset();
    for (int n = 0; n < 13; n++) begin
      drive(1'b0, '0, n < 11);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid_run[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    got = sample();
    total++;
    if (got !== m_out) begin
      bad++;
      $display("FAIL reset_mid_async: got %s want %s", fmt(got), fmt(m_out));
    end
    @(posedge clk);
    #1;
    got = sample();
    total++;
    if (got !== m_out) begin
      bad++;
      $display("FAIL reset_mid_hold: got %s want %s", fmt(got), fmt(m_out));
    end
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, '0, 1'b1);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid_restart[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_random();
    exp_t got;
    exp_t want;
    for (int n = 0; n < 200; n++) begin
      drive($urandom_range(0, 19) == 0, AW'($urandom), $urandom_range(0, 9) < 7);
      got = sample();
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL random[%0d]: got %s want %s", n, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef FETCH_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
